// File: rtl/tree_accum_pipe.sv
// tree_accum_pipe: a fully registered NUM_IN-lane signed adder tree that feeds a multi-beat group accumulator.
// Define TREE_ACCUM_SAT_EN for clamped accumulation with a sticky out_sat flag. Without it the add wraps and out_sat is 0.
module tree_accum_pipe #(
   parameter int WIDTH     = 16,
   parameter int NUM_IN    = 8,
   parameter int OUT_WIDTH = 32,
   parameter int CNT_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic                        clr,
   input  logic [NUM_IN*WIDTH-1:0]     in_data,
   input  logic                        in_valid,
   input  logic                        in_last,
   output logic signed [OUT_WIDTH-1:0] out_data,
   output logic                        out_valid,
   output logic [CNT_WIDTH-1:0]        out_beats,
   output logic                        out_sat
);
   localparam int LOG2N = $clog2(NUM_IN);
   localparam int NSTG  = LOG2N + 2;   // tree stages 0..LOG2N plus the sign-extension stage

   logic [NSTG-1:0]             vld_q, lst_q;
   logic signed [OUT_WIDTH-1:0] ext_q;
   logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         lst_q <= '0;
      end else if (clr) begin
         vld_q <= '0;
         lst_q <= '0;
      end else if (en) begin
         vld_q <= {vld_q[NSTG-2:0], in_valid};
         lst_q <= {lst_q[NSTG-2:0], in_valid & in_last};
      end
   end

   for (genvar s = 0; s <= LOG2N; s++) begin : g_stg
      localparam int SW = WIDTH + s;
      localparam int NL = NUM_IN >> s;
      logic signed [SW-1:0] sum_q [NL];

      if (s == 0) begin : g_in
         // NOTE: the lane arrays are real pipeline flops, not RAM, so every entry is reset and cleared.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < NL; i++) sum_q[i] <= '0;
            end else if (clr) begin
               for (int i = 0; i < NL; i++) sum_q[i] <= '0;
            end else if (en) begin
               for (int i = 0; i < NL; i++) sum_q[i] <= signed'(in_data[i*WIDTH +: WIDTH]);
            end
         end
      end else begin : g_add
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < NL; i++) sum_q[i] <= '0;
            end else if (clr) begin
               for (int i = 0; i < NL; i++) sum_q[i] <= '0;
            end else if (en) begin
               for (int i = 0; i < NL; i++)
                  sum_q[i] <= SW'(g_stg[s-1].sum_q[2*i]) + SW'(g_stg[s-1].sum_q[2*i+1]);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    ext_q <= '0;
      else if (clr)  ext_q <= '0;
      else if (en)   ext_q <= OUT_WIDTH'(g_stg[LOG2N].sum_q[0]);
   end

   assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

`ifdef TREE_ACCUM_SAT_EN
   logic signed [OUT_WIDTH:0] wide;
   logic                      clamp;
   logic                      sat_q;

   // NOTE: acc_d gets a default before the clamp overrides, so the block never infers a latch.
   always_comb begin
      wide  = {acc_q[OUT_WIDTH-1], acc_q} + {ext_q[OUT_WIDTH-1], ext_q};
      clamp = wide[OUT_WIDTH] ^ wide[OUT_WIDTH-1];
      acc_d = wide[OUT_WIDTH-1:0];
      if (clamp && wide[OUT_WIDTH])  acc_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      if (clamp && !wide[OUT_WIDTH]) acc_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_q   <= 1'b0;
         out_sat <= 1'b0;
      end else if (clr) begin
         sat_q   <= 1'b0;
         out_sat <= 1'b0;
      end else if (en && vld_q[NSTG-1]) begin
         if (lst_q[NSTG-1]) begin
            out_sat <= sat_q | clamp;
            sat_q   <= 1'b0;
         end else begin
            sat_q   <= sat_q | clamp;
         end
      end
   end
`else
   assign acc_d   = acc_q + ext_q;
   assign out_sat = 1'b0;
`endif

   // out_data and out_beats hold between groups. out_valid pulses once per group.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         out_data  <= '0;
         out_beats <= '0;
         out_valid <= 1'b0;
      end else if (clr) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         out_data  <= '0;
         out_beats <= '0;
         out_valid <= 1'b0;
      end else if (en) begin
         out_valid <= 1'b0;
         if (vld_q[NSTG-1]) begin
            if (lst_q[NSTG-1]) begin
               out_data  <= acc_d;
               out_beats <= cnt_d;
               out_valid <= 1'b1;
               acc_q     <= '0;
               cnt_q     <= '0;
            end else begin
               acc_q     <= acc_d;
               cnt_q     <= cnt_d;
            end
         end
      end
   end
endmodule
